// File: rtl/fp_sqrt_pkg.sv
// Shared constants, state/class encodings and operand classification for fp_sqrt_core.
package fp_sqrt_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int ITER_N = 25;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, ITER, PACK} state_t;
  typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN_OUT} cls_t;

  function automatic cls_t classify(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = x[30:23];
    f = x[22:0];
    if (e == '0)
      classify = ZERO;
    else if (e == '1 && f != '0)
      classify = NAN_OUT;
    else if (x[31])
      classify = NAN_OUT;
    else if (e == '1)
      classify = INF;
    else
      classify = NORMAL;
  endfunction

endpackage

// File: rtl/fp_sqrt_root_step.sv
// One restoring square-root step: brings in two radicand bits, tries root*4+1, emits one root bit.
module fp_sqrt_root_step
  import fp_sqrt_pkg::*;
(
  input  logic [25:0] part_rem,
  input  logic [24:0] part_root,
  input  logic [1:0]  rad_bits,
  output logic [27:0] new_rem,
  output logic        root_bit
);

  logic [27:0] shifted;
  logic [27:0] trial;

  always_comb begin
    shifted  = {part_rem, rad_bits};
    trial    = {1'b0, part_root, 2'b01};
    root_bit = (shifted >= trial);
    new_rem  = root_bit ? (shifted - trial) : shifted;
  end

endmodule

// File: rtl/fp_sqrt_core.sv
// Multi-cycle binary32 square root, RNE, fixed 27-cycle latency.
// Optional status flags output enabled by defining FP_SQRT_STATUS_EN.
module fp_sqrt_core
  import fp_sqrt_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] data_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 busy,
`ifdef FP_SQRT_STATUS_EN
  output logic [1:0]           flags,
`endif
  output logic                 done
);

  state_t state_q, state_d;
  cls_t   cls_q;

  logic [DATAWIDTH-1:0] opr_q;
  logic [4:0]           cnt_q;
  logic [49:0]          rad_q;
  logic [27:0]          rem_q;
  logic [24:0]          root_q;
  logic [7:0]           exp_q;

  logic [27:0] step_rem;
  logic        step_bit;

  fp_sqrt_root_step u_step (
    .part_rem (rem_q[25:0]),
    .part_root(root_q),
    .rad_bits (rad_q[49:48]),
    .new_rem  (step_rem),
    .root_bit (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // ITER spends its first cycle aligning the operand, then 25 cycles iterating.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: if (start) state_d = ITER;
      ITER: if (cnt_q == 5'(ITER_N)) state_d = PACK;
      PACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (start) begin
          opr_q <= data_i;
          cls_q <= classify(data_i);
          cnt_q <= '0;
        end
      end
      ITER: begin
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == '0) begin
          // Even biased exponent means odd unbiased exponent: pre-shift mantissa by one.
          rad_q  <= opr_q[23] ? {2'b01, opr_q[22:0], 25'b0} : {1'b1, opr_q[22:0], 26'b0};
          rem_q  <= '0;
          root_q <= '0;
          exp_q  <= {1'b0, opr_q[30:24]} + 8'(BIAS / 2) + {7'b0, opr_q[23]};
        end else begin
          rad_q  <= {rad_q[47:0], 2'b00};
          rem_q  <= step_rem;
          root_q <= {root_q[23:0], step_bit};
        end
      end
      default: ;
    endcase
  end

  logic        guard, sticky, rnd_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_out;
  logic [31:0] result;
  logic [1:0]  status;

  always_comb begin
    guard    = root_q[0];
    sticky   = (rem_q != '0);
    rnd_up   = guard & (sticky | root_q[1]);
    frac_sum = {1'b0, root_q[23:1]} + {23'b0, rnd_up};
    exp_out  = exp_q + {7'b0, frac_sum[23]};
    result   = '0;
    status   = '0;
    case (cls_q)
      ZERO:    result = {opr_q[31], 31'b0};
      INF:     result = PINF;
      NAN_OUT: begin
        result    = QNAN;
        status[1] = 1'b1;
      end
      default: begin
        result    = {1'b0, exp_out, frac_sum[22:0]};
        status[0] = guard | sticky;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == PACK) begin
        data_o <= result;
        done   <= 1'b1;
      end
    end
  end

`ifdef FP_SQRT_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst)
      flags <= '0;
    else if (state_q == PACK)
      flags <= status;
  end
`else
  logic unused_status;
  assign unused_status = ^status;
`endif

endmodule

// File: tb/tb_fp_sqrt_core.sv
// Self-checking bench for fp_sqrt_core: directed specials, timing, reset abort, random normals vs real-arithmetic model.
module tb_fp_sqrt_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        busy;
  logic        done;
`ifdef FP_SQRT_STATUS_EN
  logic [1:0]  flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_sqrt_core #(.DATAWIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data_i(data_i),
    .data_o(data_o),
    .busy  (busy),
`ifdef FP_SQRT_STATUS_EN
    .flags (flags),
`endif
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact real sqrt in double precision, then RNE to binary32.
  function automatic logic [33:0] ref_sqrt(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] de;
    logic [22:0] keep;
    logic        g, st, up;
    logic [31:0] r;
    real         xv, yv;
    int          e;
    e = int'(x[30:23]);
    if (e == 0)                         return {2'b00, x[31], 31'b0};
    if (e == 255 && x[22:0] != 23'b0)   return {2'b10, 32'h7FC0_0000};
    if (x[31])                          return {2'b10, 32'h7FC0_0000};
    if (e == 255)                       return {2'b00, 32'h7F80_0000};
    de   = 11'(e + 896);
    d    = {1'b0, de, x[22:0], 29'b0};
    xv   = $bitstoreal(d);
    yv   = $sqrt(xv);
    d    = $realtobits(yv);
    keep = d[51:29];
    g    = d[28];
    st   = (d[27:0] != 28'b0);
    up   = g & (st | keep[0]);
    r    = {1'b0, 8'(int'(d[62:52]) - 896), keep};
    r    = r + {31'b0, up};
    return {1'b0, g | st, r};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] alt, input int hold, input string tag);
    int          lat;
    int          busy_cnt;
    logic [33:0] exp;
    exp      = ref_sqrt(x);
    lat      = 0;
    busy_cnt = 0;
    data_i   = x;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (hold <= 1) start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) data_i = alt;
      if (c >= hold - 1) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd27);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd27);
    check({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    check({tag, ".data"}, data_o, exp[31:0]);
`ifdef FP_SQRT_STATUS_EN
    check({tag, ".flags"}, {30'b0, flags}, {30'b0, exp[33:32]});
`endif
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, ".held"}, data_o, exp[31:0]);
  endtask

  logic [31:0] directed [14];
  logic [31:0] table_exp [14];

  initial begin
    int dcount;
    rst    = 1'b1;
    start  = 1'b0;
    data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.data", data_o, 32'h0);
    check("reset.busy", {31'b0, busy}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
`ifdef FP_SQRT_STATUS_EN
    check("reset.flags", {30'b0, flags}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed  = '{32'h4080_0000, 32'h4000_0000, 32'h4110_0000, 32'h3E80_0000,
                  32'hBF80_0000, 32'h7F80_0000, 32'h7FA0_0000, 32'h8000_0000,
                  32'h0000_0001, 32'h8000_0001, 32'hFF80_0000, 32'h3F80_0000,
                  32'h0080_0000, 32'h7F7F_FFFF};
    table_exp = '{32'h4000_0000, 32'h3FB5_04F3, 32'h4040_0000, 32'h3F00_0000,
                  32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000,
                  32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h3F80_0000,
                  32'h2000_0000, 32'h5F7F_FFFF};
    foreach (directed[i]) begin
      run_op(directed[i], directed[i], 1, $sformatf("dir%0d", i));
      check($sformatf("dir%0d.table", i), data_o, table_exp[i]);
    end

    // start held two edges, operand swapped mid-iteration
    run_op(32'h4080_0000, 32'h4110_0000, 2, "hold2");

    // reset partway through 2.0
    data_i = 32'h4000_0000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.data", data_o, 32'h0);
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort.no_done", 32'(dcount), 32'd0);
    check("abort.data_after", data_o, 32'h0);
    run_op(32'h4080_0000, 32'h4080_0000, 1, "after_abort");

    for (int i = 0; i < 100; i++) begin
      logic [31:0] x;
      x = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      run_op(x, 32'($urandom), 3, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
